// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM state
// encoding, fault causes and the request classification helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SB  = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_ILLEGAL_OP = 2'd1,
    FAULT_RANGE      = 2'd2,
    FAULT_MISALIGN   = 2'd3
  } fault_cause_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LW) ||
           (op == OP_SB) || (op == OP_SW);
  endfunction

  function automatic logic op_is_load(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LW);
  endfunction

  function automatic logic op_is_byte(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
  endfunction

  function automatic logic op_is_word(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // First matching cause wins: illegal op, then range, then alignment.
  function automatic fault_cause_t fault_check(input logic [2:0]  op,
                                               input logic [31:0] addr,
                                               input logic [31:0] limit);
    if (!op_is_legal(op))                        return FAULT_ILLEGAL_OP;
    else if (addr >= limit)                      return FAULT_RANGE;
    else if (op_is_word(op) && addr[1:0] != 2'b00) return FAULT_MISALIGN;
    else                                         return FAULT_NONE;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus between the execute stage and the load/store unit.
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// a response transfers on an edge where resp_valid && resp_ready. The side
// raising valid keeps its payload stable until that edge.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_fault;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_fault
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd, resp_fault
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Load result formatting: sign/zero extension of the low byte for byte
// loads, full word pass-through for word loads.
module load_extend
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] data,
  output logic [31:0] result
);

  // Select extension by load type; non-load ops pass the word unchanged.
  always_comb begin
    result = data;
    case (op)
      OP_LB:   result = {{24{data[7]}}, data[7:0]};
      OP_LBU:  result = {24'h000000, data[7:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit. Accepts one request at a time, checks
// it for faults, performs one memory access and returns one response.
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int MEM_BYTES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  load_store_unit_if.slave     lsu,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_write_data,
  output logic                 mem_write_enable,
  output logic                 mem_read_enable,
  output logic                 mem_byte_enable,
  input  logic [31:0]          mem_read_data,
  output lsu_state_t           state
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  lsu_state_t   state_next;
  fault_cause_t cause;
  logic         accept;
  logic [2:0]   op_q;
  logic [4:0]   rd_q;
  logic [31:0]  resp_data_q;
  logic         fault_q;
  logic [31:0]  ext_data;

  assign cause  = fault_check(lsu.req_op, lsu.req_addr, MEM_LIMIT);
  assign accept = lsu.req_valid && (state == ST_IDLE);

  load_extend u_load_extend (
    .op     (op_q),
    .data   (mem_read_data),
    .result (ext_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; memory enables are only ever raised in ACCESS.
  always_comb begin
    state_next       = state;
    lsu.req_ready    = 1'b0;
    lsu.resp_valid   = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_byte_enable  = 1'b0;
    case (state)
      ST_IDLE: begin
        lsu.req_ready = 1'b1;
        if (lsu.req_valid) begin
          state_next = (cause != FAULT_NONE) ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_read_enable  = op_is_load(op_q);
        mem_write_enable = !op_is_load(op_q);
        mem_byte_enable  = op_is_byte(op_q);
        state_next       = op_is_load(op_q) ? ST_CAPTURE : ST_RESP;
      end
      ST_CAPTURE: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        lsu.resp_valid = 1'b1;
        if (lsu.resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latching and response capture; the response fields only change
  // at acceptance or in CAPTURE, so they are stable throughout RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q           <= OP_LB;
      rd_q           <= '0;
      resp_data_q    <= '0;
      fault_q        <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      if (accept) begin
        op_q        <= lsu.req_op;
        rd_q        <= lsu.req_rd;
        resp_data_q <= '0;
        fault_q     <= (cause != FAULT_NONE);
        if (cause == FAULT_NONE) begin
          mem_address    <= lsu.req_addr;
          mem_write_data <= lsu.req_wdata;
        end
      end
      if (state == ST_CAPTURE) begin
        resp_data_q <= ext_data;
      end
    end
  end

  assign lsu.resp_data  = resp_data_q;
  assign lsu.resp_rd    = rd_q;
  assign lsu.resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte memory,
// a response scoreboard and per-request access/latency checks.
module tb_load_store_unit;
  import riscv_lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic        mem_byte_enable;
  lsu_state_t  dbg_state;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk              (clk),
    .rst              (rst),
    .lsu              (bus),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_byte_enable  (mem_byte_enable),
    .mem_read_data    (mem_read_data),
    .state            (dbg_state)
  );

  // ---------------- data memory model ----------------
  logic [7:0] mem_b [0:4095];

  always @(posedge clk) begin
    int a;
    a = int'(mem_address[11:0]);
    if (mem_write_enable) begin
      if (mem_byte_enable) mem_b[a] = mem_write_data[7:0];
      else for (int k = 0; k < 4; k++) mem_b[a + k] = mem_write_data[8*k +: 8];
    end
    if (mem_read_enable) begin
      if (mem_byte_enable) mem_read_data <= {24'hA5A5A5, mem_b[a]};
      else mem_read_data <= {mem_b[a + 3], mem_b[a + 2], mem_b[a + 1], mem_b[a]};
    end
  end

  // ---------------- scoreboard ----------------
  logic [37:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected {fault, rd, data} per response handshake.
  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected response", 32'(bus.resp_rd), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", bus.resp_data, e[31:0]);
        chk("resp_rd", 32'(bus.resp_rd), 32'(e[36:32]));
        chk("resp_fault", 32'(bus.resp_fault), 32'(e[37]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string where);
    chk({where, " state"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({where, " req_ready"}, 32'(bus.req_ready), 1);
    chk({where, " resp_valid"}, 32'(bus.resp_valid), 0);
    chk({where, " resp_data"}, bus.resp_data, 0);
    chk({where, " resp_rd"}, 32'(bus.resp_rd), 0);
    chk({where, " resp_fault"}, 32'(bus.resp_fault), 0);
    chk({where, " mem_address"}, mem_address, 0);
    chk({where, " mem_write_data"}, mem_write_data, 0);
    chk({where, " mem enables"},
        {29'd0, mem_write_enable, mem_read_enable, mem_byte_enable}, 0);
  endtask

  task automatic run_req(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] exp_data, input logic exp_fault,
                         input int hold);
    int n, lat, rd_cnt, wr_cnt, exp_lat, exp_rd_cnt, exp_wr_cnt;
    logic exp_byte;
    string tag;
    tag = $sformatf("op=%b addr=%h", op, addr);
    exp_byte = (op == 3'b000) || (op == 3'b001) || (op == 3'b100);
    if (exp_fault)    begin exp_lat = 1; exp_rd_cnt = 0; exp_wr_cnt = 0; end
    else if (!op[2])  begin exp_lat = 3; exp_rd_cnt = 1; exp_wr_cnt = 0; end
    else              begin exp_lat = 2; exp_rd_cnt = 0; exp_wr_cnt = 1; end

    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_rd = rd;
    exp_q.push_back({exp_fault, rd, exp_data});
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, " accept"}, 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_op = 3'b111; bus.req_addr = $urandom;
    bus.req_wdata = $urandom; bus.req_rd = 5'($urandom_range(0, 31));

    lat = 0; rd_cnt = 0; wr_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_read_enable) begin
        rd_cnt++;
        chk({tag, " rd mem_address"}, mem_address, addr);
        chk({tag, " rd byte_enable"}, 32'(mem_byte_enable), 32'(exp_byte));
      end
      if (mem_write_enable) begin
        wr_cnt++;
        chk({tag, " wr mem_address"}, mem_address, addr);
        chk({tag, " wr mem_write_data"}, mem_write_data, wdata);
        chk({tag, " wr byte_enable"}, 32'(mem_byte_enable), 32'(exp_byte));
      end
    end while (!bus.resp_valid && lat < 20);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " read enables"}, 32'(rd_cnt), 32'(exp_rd_cnt));
    chk({tag, " write enables"}, 32'(wr_cnt), 32'(exp_wr_cnt));

    // Back-pressure: offer a competing store while the response waits.
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_op = OP_SW;
      bus.req_addr = 32'h80; bus.req_wdata = 32'h5555_AAAA;
      @(negedge clk);
      chk({tag, " hold resp_valid"}, 32'(bus.resp_valid), 1);
      chk({tag, " hold resp_data"}, bus.resp_data, exp_data);
      chk({tag, " hold resp_rd"}, 32'(bus.resp_rd), 32'(rd));
      chk({tag, " hold resp_fault"}, 32'(bus.resp_fault), 32'(exp_fault));
      chk({tag, " hold req_ready"}, 32'(bus.req_ready), 0);
      chk({tag, " hold enables"}, {30'd0, mem_write_enable, mem_read_enable}, 0);
    end

    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, " back to idle"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, " req_ready after resp"}, 32'(bus.req_ready), 1);
    chk({tag, " resp_valid after resp"}, 32'(bus.resp_valid), 0);
    chk({tag, " no stray access"}, {30'd0, mem_write_enable, mem_read_enable}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem_b[i] = 8'h00;
    mem_read_data = '0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_rd = '0; bus.resp_ready = 1'b0;
    rst = 1'b1;
    #12;
    check_reset_outputs("in reset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after reset");

    //       op      addr           wdata          rd     exp_data       flt  hold
    run_req(OP_SW,  32'h0000_0010, 32'hDEAD_BEEF, 5'd1,  32'h0000_0000, 1'b0, 0);
    run_req(OP_LW,  32'h0000_0010, 32'h0,         5'd2,  32'hDEAD_BEEF, 1'b0, 0);
    run_req(OP_SB,  32'h0000_0021, 32'h0000_0080, 5'd3,  32'h0000_0000, 1'b0, 0);
    run_req(OP_LB,  32'h0000_0021, 32'h0,         5'd4,  32'hFFFF_FF80, 1'b0, 0);
    run_req(OP_LBU, 32'h0000_0021, 32'h0,         5'd5,  32'h0000_0080, 1'b0, 0);
    run_req(OP_LW,  32'h0000_0013, 32'h0,         5'd6,  32'h0000_0000, 1'b1, 0);
    run_req(3'b111, 32'h0000_0020, 32'h1234_5678, 5'd7,  32'h0000_0000, 1'b1, 0);
    run_req(OP_SW,  32'h0000_0FFC, 32'hCAFE_F00D, 5'd8,  32'h0000_0000, 1'b0, 0);
    run_req(OP_LW,  32'h0000_0FFC, 32'h0,         5'd9,  32'hCAFE_F00D, 1'b0, 5);
    run_req(OP_LW,  32'h0000_1000, 32'h0,         5'd10, 32'h0000_0000, 1'b1, 0);
    run_req(OP_SB,  32'h0000_0FFF, 32'h1234_567F, 5'd11, 32'h0000_0000, 1'b0, 0);
    run_req(OP_LBU, 32'h0000_0FFF, 32'h0,         5'd12, 32'h0000_007F, 1'b0, 0);
    run_req(OP_LW,  32'h0000_0FFD, 32'h0,         5'd13, 32'h0000_0000, 1'b1, 2);
    run_req(OP_SW,  32'h0000_0FFE, 32'h1111_2222, 5'd14, 32'h0000_0000, 1'b1, 0);
    run_req(OP_LB,  32'h0000_0010, 32'h0,         5'd15, 32'hFFFF_FFEF, 1'b0, 0);
    run_req(OP_LBU, 32'h0000_0013, 32'h0,         5'd16, 32'h0000_00DE, 1'b0, 0);
    run_req(OP_SB,  32'h0000_0011, 32'hFFFF_FF00, 5'd17, 32'h0000_0000, 1'b0, 0);
    run_req(OP_LW,  32'h0000_0010, 32'h0,         5'd18, 32'hDEAD_00EF, 1'b0, 0);
    run_req(3'b011, 32'h0000_0010, 32'h0,         5'd19, 32'h0000_0000, 1'b1, 0);
    run_req(3'b101, 32'h0000_0011, 32'h0,         5'd20, 32'h0000_0000, 1'b1, 0);
    run_req(OP_SB,  32'h0000_0FFD, 32'h0000_00C3, 5'd21, 32'h0000_0000, 1'b0, 0);
    run_req(OP_LB,  32'h0000_0FFD, 32'h0,         5'd22, 32'hFFFF_FFC3, 1'b0, 0);

    // Reset while a word store is in its ACCESS cycle.
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = OP_SW; bus.req_addr = 32'h40;
    bus.req_wdata = 32'h1234_5678; bus.req_rd = 5'd23;
    @(negedge clk);
    chk("rst test accept", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst test in access", 32'(dbg_state), 32'(ST_ACCESS));
    chk("rst test write enable", 32'(mem_write_enable), 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid-op reset");
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-reset quiet", {30'd0, mem_write_enable, bus.resp_valid}, 0);
    end
    chk("abandoned store not written",
        {mem_b[16'h43], mem_b[16'h42], mem_b[16'h41], mem_b[16'h40]}, 32'h0);
    run_req(OP_LW,  32'h0000_0010, 32'h0,         5'd24, 32'hDEAD_00EF, 1'b0, 0);
    run_req(OP_LW,  32'h0000_0040, 32'h0,         5'd25, 32'h0000_0000, 1'b0, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
